// File: rtl/pos_scan_pkg.sv
// Shared types for the position scan controller: code type, FSM states, event record.
// Optional POS_SCAN_DIR_EN adds a direction bit to each event.
package pos_scan_pkg;

  typedef logic [4:0] pos_code_t;

  localparam pos_code_t POS_NONE    = 5'd0;
  localparam pos_code_t POS_INVALID = 5'd17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SMP_A = 2'd1,
    SMP_B = 2'd2,
    UPD   = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic      ch;
    pos_code_t pos;
    pos_code_t prev;
`ifdef POS_SCAN_DIR_EN
    logic      dir;
`endif
  } pos_evt_t;

  function automatic pos_evt_t make_evt(input logic ch, input pos_code_t pos, input pos_code_t prev);
    pos_evt_t evt;
    evt      = '0;
    evt.ch   = ch;
    evt.pos  = pos;
    evt.prev = prev;
`ifdef POS_SCAN_DIR_EN
    // Direction only means something between two real sensor positions.
    evt.dir  = (pos >= 5'd1) && (pos <= 5'd16) && (prev >= 5'd1) && (prev <= 5'd16) && (pos > prev);
`endif
    return evt;
  endfunction

endpackage

// File: rtl/pos_onehot_enc.sv
// Combinational one-hot to position-code encoder: 0 none, k+1 for single bit k, 17 otherwise.
// Zero latency; no flow control.
module pos_onehot_enc
  import pos_scan_pkg::*;
(
  input  logic [15:0] onehot,
  output logic [4:0]  code
);

  logic [4:0] idx;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) idx = 5'(i + 1);
    end
    if (onehot == 16'd0)
      code = POS_NONE;
    else if ((onehot & (onehot - 16'd1)) != 16'd0)
      code = POS_INVALID;
    else
      code = idx;
  end

endmodule

// File: rtl/pos_scan_ctrl.sv
// Two-channel one-hot position scanner with shared encoder, per-channel debounce and 2-entry event FIFO.
// Accepts a steady code after DEB_N ticks; events held under evt_valid && !evt_ready, full-FIFO pushes dropped (POS_SCAN_DIR_EN adds evt_dir).
module pos_scan_ctrl
  import pos_scan_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int DEB_N      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [4:0]  pos_a,
  output logic [4:0]  pos_b,
  output logic        fault_a,
  output logic        fault_b,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_ch,
  output logic [4:0]  evt_pos,
  output logic [4:0]  evt_prev,
`ifdef POS_SCAN_DIR_EN
  output logic        evt_dir,
`endif
  output logic        overrun,
  input  logic        ovr_clr
);

  localparam int              DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [3:0]      DEB_MAX  = 4'(DEB_N);

  logic [15:0]      ra, rb;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  scan_state_t      state;
  pos_code_t        sa, sb;
  logic [15:0]      enc_in;
  pos_code_t        enc_code;

  pos_code_t        cand_q   [2];
  logic [3:0]       cnt_q    [2];
  pos_code_t        stable_q [2];
  pos_code_t        nxt_cand [2];
  logic [3:0]       nxt_cnt  [2];
  logic [1:0]       chg;

  pos_evt_t         fifo_q [2];
  pos_evt_t         fifo_d [2];
  logic [1:0]       fifo_cnt, fifo_cnt_d;
  logic             pop, drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      ra      <= '0;
      rb      <= '0;
      div_cnt <= '0;
    end else begin
      ra <= in_a;
      rb <= in_b;
      if (!enable || div_cnt == DIV_LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = enable && (div_cnt == DIV_LAST);

  // One encoder serves both groups; the FSM state selects which one it sees.
  assign enc_in = (state == SMP_B) ? rb : ra;

  pos_onehot_enc u_enc (
    .onehot (enc_in),
    .code   (enc_code)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sa    <= POS_NONE;
      sb    <= POS_NONE;
    end else begin
      case (state)
        IDLE:    if (tick) state <= SMP_A;
        SMP_A: begin
          sa    <= enc_code;
          state <= SMP_B;
        end
        SMP_B: begin
          sb    <= enc_code;
          state <= UPD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      nxt_cand[ch] = cand_q[ch];
      nxt_cnt[ch]  = cnt_q[ch];
      if (((ch == 0) ? sa : sb) == cand_q[ch]) begin
        nxt_cnt[ch] = (cnt_q[ch] >= DEB_MAX) ? DEB_MAX : cnt_q[ch] + 4'd1;
      end else begin
        nxt_cand[ch] = (ch == 0) ? sa : sb;
        nxt_cnt[ch]  = 4'd1;
      end
      chg[ch] = (nxt_cnt[ch] == DEB_MAX) && (nxt_cand[ch] != stable_q[ch]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        cand_q[ch]   <= POS_NONE;
        cnt_q[ch]    <= '0;
        stable_q[ch] <= POS_NONE;
      end
    end else if (state == UPD) begin
      for (int ch = 0; ch < 2; ch++) begin
        cand_q[ch] <= nxt_cand[ch];
        cnt_q[ch]  <= nxt_cnt[ch];
        if (chg[ch]) stable_q[ch] <= nxt_cand[ch];
      end
    end
  end

  assign pos_a   = stable_q[0];
  assign pos_b   = stable_q[1];
  assign fault_a = (stable_q[0] == POS_INVALID);
  assign fault_b = (stable_q[1] == POS_INVALID);

  assign pop = evt_valid && evt_ready;

  // Pop first so its slot is reusable this cycle; then A, then B claim free slots.
  always_comb begin
    fifo_d[0]  = fifo_q[0];
    fifo_d[1]  = fifo_q[1];
    fifo_cnt_d = fifo_cnt;
    drop       = 1'b0;
    if (pop) begin
      fifo_d[0]  = fifo_q[1];
      fifo_cnt_d = fifo_cnt - 2'd1;
    end
    if (state == UPD) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (chg[ch]) begin
          if (fifo_cnt_d == 2'd2) begin
            drop = 1'b1;
          end else begin
            fifo_d[fifo_cnt_d[0]] = make_evt(ch[0], nxt_cand[ch], stable_q[ch]);
            fifo_cnt_d            = fifo_cnt_d + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifo_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      fifo_cnt  <= fifo_cnt_d;
      if (drop)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  assign evt_valid = (fifo_cnt != 2'd0);
  assign evt_ch    = fifo_q[0].ch;
  assign evt_pos   = fifo_q[0].pos;
  assign evt_prev  = fifo_q[0].prev;
`ifdef POS_SCAN_DIR_EN
  assign evt_dir   = fifo_q[0].dir;
`endif

endmodule

// File: doc/pos_scan_ctrl.md
Name: pos_scan_ctrl

Overview:
- Sequencer and arbiter for two 16-bit one-hot position sensor groups (A, B) sharing one one-hot-to-code encoder.
- Time-multiplexes the encoder between A and B at a programmable sample rate.
- Debounces each channel's code and holds a stable position and fault flag per channel.
- Reports position changes to the host through a 2-entry event FIFO with a valid/ready handshake.

Parameters:
- SAMPLE_DIV, 4: clocks per sample tick (≥4); one A+B scan per tick.
- DEB_N, 3: consecutive identical samples required to accept a code (1..15).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  1 = scanning runs; 0 = divider and FSM held in IDLE, state retained
- in_a  in  16  sensor group A, asynchronous, registered once on entry
- in_b  in  16  sensor group B, asynchronous, registered once on entry
- pos_a  out  5  stable code A: 0 none, 1..16 bit index+1, 17 invalid
- pos_b  out  5  stable code B, same encoding
- fault_a  out  1  pos_a == 17
- fault_b  out  1  pos_b == 17
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  host accepts head when evt_valid && evt_ready
- evt_ch  out  1  0 = A, 1 = B
- evt_pos  out  5  new stable code
- evt_prev  out  5  previous stable code
- overrun  out  1  sticky: an event was dropped
- ovr_clr  in  1  clears overrun (set wins if same cycle)

Behaviour:
- Reset: all outputs 0; debounce candidates 0; counts 0; FIFO empty; FSM IDLE; divider 0.
- Input stage: in_a/in_b registered every clock into ra/rb.
- Encoder code: 0 if all-zero; k+1 if exactly bit k set; 17 otherwise.
- Divider: counts 0..SAMPLE_DIV-1 while enable=1; tick when count == SAMPLE_DIV-1.
- FSM:
  - IDLE: on tick -> SMP_A.
  - SMP_A: encoder mux = ra; code latched into sa; -> SMP_B.
  - SMP_B: mux = rb; latched into sb; -> UPD.
  - UPD: debounce update and event push; -> IDLE.
  - Each state lasts 1 clock, so a scan takes 3 clocks.
- Debounce per channel, in UPD:
  - If sample == cand: cnt = min(cnt+1, DEB_N).
  - Else: cand = sample, cnt = 1.
  - When the new cnt == DEB_N and cand != stable: stable <= cand, and push event {ch, cand, old stable}.
  - pos/fault update at the clock edge ending UPD.
- Latency: a steady input change becomes visible on pos_x after DEB_N ticks, at most DEB_N×SAMPLE_DIV+4 clocks.
- FIFO: 2 entries.
  - Pop on evt_valid && evt_ready.
  - Pushes occur only in UPD; A is pushed before B.
  - A pop in the same cycle frees its slot before the pushes.
  - A push into a full FIFO is dropped and sets overrun. If both channels change with one free slot, A is stored and B is dropped.
  - Head outputs stay stable while evt_valid && !evt_ready.
- enable low mid-scan: FSM finishes the current scan to IDLE, then holds; the divider resets to 0.
- reset mid-operation: all state returns to reset values the next clock; pending events are discarded.

Optional Feature:
- POS_SCAN_DIR_EN defined: adds output port evt_dir (1 bit), stored per FIFO entry.
  - evt_dir = 1 when evt_pos and evt_prev are both in 1..16 and evt_pos > evt_prev.
  - evt_dir = 0 otherwise.
- Undefined: port and storage absent; all other behaviour identical.

Decomposition:
- Package pos_scan_pkg holds:
  - 5-bit code typedef.
  - Constants POS_NONE=0, POS_INVALID=17.
  - FSM state enum {IDLE, SMP_A, SMP_B, UPD}.
  - Event struct {ch, pos, prev[, dir]}.
- Sub-module pos_onehot_enc: combinational 16-bit -> 5-bit encoder, instantiated once and shared through the mux.
- FIFO and debounce stay inline.

Test Plan (defaults SAMPLE_DIV=4, DEB_N=3):
- Reset, then in_a=0x0008 held, evt_ready=1 -> after 3 ticks pos_a=4; one event {ch0, pos 4, prev 0}; fault_a=0.
- in_b=0x0300 held -> pos_b=17, fault_b=1; event {ch1, 17, 0}.
- in_a glitches 0x0008->0x0010 for 2 ticks, then back -> no event; pos_a stays 4.
- A and B change in the same scan, evt_ready=0 -> two events, A first then B; a third change (A) -> dropped, overrun=1.
  - ovr_clr pulse -> overrun=0.
- With POS_SCAN_DIR_EN: A 4->7 gives evt_dir=1; 7->2 gives evt_dir=0; 0->5 gives evt_dir=0.
- enable=0 mid-scan, change in_a for 40 clocks -> no update; enable=1 -> pos_a updates after 3 ticks.
  - Reset pulse with a pending event -> evt_valid=0 and all outputs 0 the next clock.
